// File: rtl/rv_halt_dump.sv
// rv_halt_dump: halts the core on a SYSTEM instruction or a cycle timeout, then streams out the register file over valid/ready
module rv_halt_dump #(
  parameter int XLEN            = 32,
  parameter int NREGS           = 32,
  parameter int IDX_W           = 5,
  parameter int CNT_W           = 32,
  parameter int TIMEOUT         = 40,
  parameter int HALT_ON_EBREAK  = 1,
  parameter int HALT_ANY_SYSTEM = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst,
  input  logic             inst_valid,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [XLEN-1:0]  rd_data,
  output logic             halt,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [IDX_W-1:0] dump_idx,
  output logic [XLEN-1:0]  dump_data,
  output logic             done
);
  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] DUMP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NREGS - 1);
  localparam logic [31:0] ECALL  = 32'h00000073;
  localparam logic [31:0] EBREAK = 32'h00100073;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_next;
  logic             is_ecall, is_ebreak, is_tmo, xfer;
  always_comb begin
    cnt_next  = &cycle_count ? cycle_count : cycle_count + 1'b1;
    is_ebreak = inst_valid && HALT_ON_EBREAK != 0 && inst == EBREAK;
    is_ecall  = inst_valid && (inst == ECALL ||
                (HALT_ANY_SYSTEM != 0 && inst[6:0] == 7'b1110011 && inst != EBREAK));
    is_tmo    = TIMEOUT != 0 && cnt_next == CNT_W'(TIMEOUT);
    xfer      = state == DUMP && dump_valid && dump_ready;
    rd_addr   = (state == DUMP && dump_idx != LAST) ? dump_idx + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      halt        <= 1'b0;
      halt_cause  <= 2'b00;
      cycle_count <= '0;
      dump_valid  <= 1'b0;
      dump_idx    <= '0;
      dump_data   <= '0;
      done        <= 1'b0;
    end else if (state == RUN) begin
      cycle_count <= cnt_next;
      if (is_ecall || is_ebreak || is_tmo) begin
        state      <= DUMP;
        halt       <= 1'b1;
        halt_cause <= is_ecall ? 2'b01 : is_ebreak ? 2'b10 : 2'b11;
        dump_valid <= 1'b1;
        dump_idx   <= '0;
        dump_data  <= '0;
      end
    end else if (xfer) begin
      if (dump_idx == LAST) begin
        state      <= DONE;
        dump_valid <= 1'b0;
        done       <= 1'b1;
      end else begin
        dump_idx  <= dump_idx + 1'b1;
        dump_data <= rd_data;
      end
    end
  end
endmodule

// File: tb/tb_rv_halt_dump.sv
// tb_rv_halt_dump: directed checks of halt decode, timeout, dump stream, backpressure and async reset
module tb_rv_halt_dump;
  logic        clk, rst, inst_valid, dump_ready;
  logic [31:0] inst;
  logic [4:0]  rd_addr_a, di_a, rd_addr_b, di_b;
  logic [31:0] rd_data_a, dd_a, rd_data_b, dd_b, cc_a, cc_b;
  logic [1:0]  cause_a, cause_b;
  logic        halt_a, dv_a, done_a, halt_b, dv_b, done_b;
  int          n_checks = 0;
  int          n_errors = 0;
  int          exp_idx;
  assign rd_data_a = rd_addr_a == 0 ? 32'hFFFFFFFF : {27'b0, rd_addr_a} * 32'd3;
  assign rd_data_b = rd_addr_b == 0 ? 32'hFFFFFFFF : {27'b0, rd_addr_b} * 32'd3;
  rv_halt_dump dut_a (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .halt(halt_a), .halt_cause(cause_a),
    .cycle_count(cc_a), .dump_valid(dv_a), .dump_ready(dump_ready),
    .dump_idx(di_a), .dump_data(dd_a), .done(done_a)
  );
  rv_halt_dump #(.TIMEOUT(10), .HALT_ON_EBREAK(0), .HALT_ANY_SYSTEM(1)) dut_b (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .halt(halt_b), .halt_cause(cause_b),
    .cycle_count(cc_b), .dump_valid(dv_b), .dump_ready(dump_ready),
    .dump_idx(di_b), .dump_data(dd_b), .done(done_b)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b0;
    inst_valid = 1'b0;
    inst = 32'h0;
    ticks(2);
    rst = 1'b1;
  endtask
  task automatic full_dump(input string tag);
    for (int k = 0; k < 32; k++) begin
      chk({tag, "_valid"}, dv_a, 1);
      chk({tag, "_done_early"}, done_a, 0);
      chk({tag, "_idx"}, di_a, k);
      chk({tag, "_data"}, dd_a, k * 3);
      tick();
    end
    chk({tag, "_done"}, done_a, 1);
    chk({tag, "_valid_end"}, dv_a, 0);
  endtask
  initial begin
    rst = 1'b0;
    inst = 32'h0;
    inst_valid = 1'b0;
    dump_ready = 1'b1;
    ticks(2);
    chk("rst_halt", halt_a, 0);
    chk("rst_cause", cause_a, 0);
    chk("rst_cc", cc_a, 0);
    chk("rst_valid", dv_a, 0);
    chk("rst_idx", di_a, 0);
    chk("rst_data", dd_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_rdaddr", rd_addr_a, 0);
    rst = 1'b1;
    // ECALL on the 5th edge; EBREAK offered during the dump must not change the cause
    ticks(4);
    chk("run_cc4", cc_a, 4);
    chk("run_halt4", halt_a, 0);
    inst = 32'h00000073;
    inst_valid = 1'b1;
    tick();
    chk("ecall_halt", halt_a, 1);
    chk("ecall_cause", cause_a, 2'b01);
    chk("ecall_cc", cc_a, 5);
    chk("ecall_b_cause", cause_b, 2'b01);
    chk("ecall_rdaddr", rd_addr_a, 1);
    inst = 32'h00100073;
    full_dump("ecall_dump");
    chk("ecall_cause_held", cause_a, 2'b01);
    chk("ecall_cc_frozen", cc_a, 5);
    chk("ecall_halt_held", halt_a, 1);
    ticks(3);
    chk("done_sticky", done_a, 1);
    chk("done_rdaddr", rd_addr_a, 0);
    // EBREAK: honoured by A, ignored by B which then times out at 10
    do_reset();
    ticks(2);
    inst = 32'h00100073;
    inst_valid = 1'b1;
    tick();
    chk("ebreak_a_cause", cause_a, 2'b10);
    chk("ebreak_a_cc", cc_a, 3);
    chk("ebreak_b_halt", halt_b, 0);
    inst_valid = 1'b0;
    ticks(6);
    chk("tmo_b_pre", halt_b, 0);
    tick();
    chk("tmo_b_halt", halt_b, 1);
    chk("tmo_b_cause", cause_b, 2'b11);
    chk("tmo_b_cc", cc_b, 10);
    chk("tmo_b_x0", dd_b, 0);
    chk("ebreak_a_cc_frozen", cc_a, 3);
    // Timeout at 40 on A, then randomly backpressured dump
    do_reset();
    ticks(39);
    chk("tmo_a_pre", halt_a, 0);
    chk("tmo_a_cc39", cc_a, 39);
    tick();
    chk("tmo_a_halt", halt_a, 1);
    chk("tmo_a_cause", cause_a, 2'b11);
    chk("tmo_a_cc", cc_a, 40);
    chk("tmo_b_cc_frozen", cc_b, 10);
    exp_idx = 0;
    for (int c = 0; c < 400 && !done_a; c++) begin
      chk("bp_valid", dv_a, 1);
      chk("bp_idx", di_a, exp_idx);
      chk("bp_data", dd_a, exp_idx * 3);
      dump_ready = (c % 4 == 1 || c % 4 == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
      if (dump_ready) exp_idx++;
    end
    chk("bp_done", done_a, 1);
    chk("bp_beats", exp_idx, 32);
    chk("bp_cc", cc_a, 40);
    dump_ready = 1'b1;
    // csrrw: halts B (any SYSTEM) only
    do_reset();
    ticks(1);
    inst = 32'h34029073;
    inst_valid = 1'b1;
    tick();
    chk("csr_a_halt", halt_a, 0);
    chk("csr_b_cause", cause_b, 2'b01);
    chk("csr_b_cc", cc_b, 2);
    // ECALL coinciding with B's timeout: instruction cause wins
    do_reset();
    ticks(9);
    inst = 32'h00000073;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    chk("simul_b_cause", cause_b, 2'b01);
    chk("simul_b_cc", cc_b, 10);
    chk("simul_a_cause", cause_a, 2'b01);
    // Asynchronous reset mid-dump, then a fresh full dump
    ticks(7);
    chk("mid_idx", di_a, 7);
    chk("mid_data", dd_a, 21);
    #1 rst = 1'b0;
    #1;
    chk("arst_halt", halt_a, 0);
    chk("arst_cause", cause_a, 0);
    chk("arst_cc", cc_a, 0);
    chk("arst_valid", dv_a, 0);
    chk("arst_idx", di_a, 0);
    chk("arst_data", dd_a, 0);
    chk("arst_done", done_a, 0);
    chk("arst_rdaddr", rd_addr_a, 0);
    tick();
    rst = 1'b1;
    ticks(2);
    inst = 32'h00000073;
    inst_valid = 1'b1;
    tick();
    inst_valid = 1'b0;
    chk("re_cause", cause_a, 2'b01);
    chk("re_cc", cc_a, 3);
    full_dump("re_dump");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
